// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared state encoding and default parameters for the run controller
package cpu_run_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    RST1 = 3'd1,
    RST2 = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_e;
  localparam int RST1_CYCLES_DEF = 1;
  localparam int RST2_CYCLES_DEF = 1;
  localparam int MAX_CYCLES_DEF  = 200;
  localparam int HALT_HOLD_DEF   = 4;
  localparam int CNT_W_DEF       = 32;
  localparam int WDOG_CYCLES_DEF = 32;
endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// sat_counter: W-bit up counter; clr beats en, holds at all-ones instead of wrapping
//   clk, rst : clock, sync active-high reset
//   clr, en  : synchronous clear, count enable
//   cnt_o    : registered count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences core rst/reset, runs the core, ends on sustained halt or cycle budget
//   start_i/abort_i : begin a run / return to IDLE from anywhere
//   halt_i/retire_i : core halt indication / one instruction retired
//   core_rst_o/core_reset_o : core reset drives; run_o/done_o/timeout_o : status
//   cycle_cnt_o/retire_cnt_o : RUN cycles and retired instructions
//   CPU_RUN_WATCHDOG_EN adds WDOG_CYCLES and wdog_o (no-retire watchdog exit)
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST1_CYCLES = RST1_CYCLES_DEF,
  parameter int RST2_CYCLES = RST2_CYCLES_DEF,
  parameter int MAX_CYCLES  = MAX_CYCLES_DEF,
  parameter int HALT_HOLD   = HALT_HOLD_DEF,
`ifdef CPU_RUN_WATCHDOG_EN
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
`endif
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             halt_i,
  input  logic             retire_i,
  output logic             core_rst_o,
  output logic             core_reset_o,
  output logic             run_o,
  output logic             done_o,
  output logic             timeout_o,
`ifdef CPU_RUN_WATCHDOG_EN
  output logic             wdog_o,
`endif
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);
  localparam int PMAX = RST1_CYCLES > RST2_CYCLES ? RST1_CYCLES : RST2_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int HW   = $clog2(HALT_HOLD + 1);
  state_e state_q, state_d;
  logic [PW-1:0] phase;
  logic [HW-1:0] streak;
  logic core_rst_q, core_rst_d, core_reset_q, core_reset_d;
  logic run_q, run_d, done_q, done_d, timeout_q, timeout_d;
  logic in_run, halt_hit, bud_hit, wd_hit, clr_cnt, exit_run;
  assign in_run   = state_q == RUN;
  assign halt_hit = in_run && halt_i && streak == HW'(HALT_HOLD - 1);
  assign bud_hit  = in_run && cycle_cnt_o == CNT_W'(MAX_CYCLES - 1);
  // phase restarts on every state change, so it counts cycles spent in RST1/RST2
  sat_counter #(.W(PW)) u_phase (
    .clk(clk), .rst(rst), .clr(state_d != state_q), .en(1'b1), .cnt_o(phase)
  );
  sat_counter #(.W(HW)) u_streak (
    .clk(clk), .rst(rst), .clr(!(in_run && halt_i)), .en(1'b1), .cnt_o(streak)
  );
  sat_counter #(.W(CNT_W)) u_cycle (
    .clk(clk), .rst(rst), .clr(clr_cnt), .en(in_run), .cnt_o(cycle_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_retire (
    .clk(clk), .rst(rst), .clr(clr_cnt), .en(in_run && retire_i), .cnt_o(retire_cnt_o)
  );
`ifdef CPU_RUN_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd;
  logic wdog_q, wdog_d;
  sat_counter #(.W(WW)) u_wdog (
    .clk(clk), .rst(rst), .clr(!in_run || retire_i), .en(1'b1), .cnt_o(wd)
  );
  assign wd_hit = in_run && !retire_i && wd == WW'(WDOG_CYCLES - 1);
`else
  assign wd_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? RST1 : IDLE;
      RST1:    state_d = phase == PW'(RST1_CYCLES - 1) ? RST2 : RST1;
      RST2:    state_d = phase == PW'(RST2_CYCLES - 1) ? RUN : RST2;
      RUN:     state_d = (halt_hit || wd_hit || bud_hit) ? DONE : RUN;
      DONE:    state_d = start_i ? RST1 : DONE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
    clr_cnt      = state_d == IDLE || state_d == RST1;
    exit_run     = in_run && state_d == DONE;
    core_rst_d   = state_d == IDLE || state_d == RST1 || state_d == DONE;
    core_reset_d = state_d == RST2;
    run_d        = state_d == RUN;
    done_d       = state_d == DONE;
    // halt outranks every timeout source on the exit cycle
    timeout_d    = clr_cnt ? 1'b0 : exit_run ? !halt_hit : timeout_q;
`ifdef CPU_RUN_WATCHDOG_EN
    wdog_d       = clr_cnt ? 1'b0 : exit_run ? (wd_hit && !halt_hit) : wdog_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      core_rst_q   <= 1'b1;
      core_reset_q <= 1'b0;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_rst_q   <= core_rst_d;
      core_reset_q <= core_reset_d;
      run_q        <= run_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end
`ifdef CPU_RUN_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= 1'b0;
    else wdog_q <= wdog_d;
  end
  assign wdog_o = wdog_q;
`endif
  assign core_rst_o   = core_rst_q;
  assign core_reset_o = core_reset_q;
  assign run_o        = run_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: table-driven and scoreboarded checks of the run controller
module tb_cpu_run_ctrl;
  logic clk = 1'b0;
  logic rst, start_i, abort_i, halt_i, retire_i;
  logic core_rst_o, core_reset_o, run_o, done_o, timeout_o;
  logic [31:0] cycle_cnt_o, retire_cnt_o;
`ifdef CPU_RUN_WATCHDOG_EN
  logic wdog_o;
`endif
  always #5 clk = ~clk;
  cpu_run_ctrl #(
    .RST1_CYCLES(2), .RST2_CYCLES(3), .MAX_CYCLES(200), .HALT_HOLD(4),
`ifdef CPU_RUN_WATCHDOG_EN
    .WDOG_CYCLES(32),
`endif
    .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .halt_i(halt_i),
    .retire_i(retire_i), .core_rst_o(core_rst_o), .core_reset_o(core_reset_o),
    .run_o(run_o), .done_o(done_o), .timeout_o(timeout_o),
`ifdef CPU_RUN_WATCHDOG_EN
    .wdog_o(wdog_o),
`endif
    .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o)
  );
  typedef struct packed {logic rst, start, abort, halt, retire;} in_t;
  typedef struct packed {logic core_rst, core_reset, run, done, timeout; logic [31:0] cc, rc;} out_t;
  typedef struct {in_t i; out_t e; string n;} vec_t;
  vec_t tbl[$];
  out_t exp_q[$];
  string name_q[$];
  int n_vec = 0, n_err = 0;
  function automatic in_t ii(logic r, logic s, logic a, logic h, logic t);
    ii = {r, s, a, h, t};
  endfunction
  function automatic out_t mk(logic cr, logic cs, logic rn, logic dn, logic to, int cc, int rc);
    mk = {cr, cs, rn, dn, to, cc[31:0], rc[31:0]};
  endfunction
  function automatic string fmt(out_t o);
    fmt = $sformatf("rst=%0b reset=%0b run=%0b done=%0b to=%0b cyc=%0d ret=%0d",
                    o.core_rst, o.core_reset, o.run, o.done, o.timeout, o.cc, o.rc);
  endfunction
  task automatic add(input in_t i, input out_t e, input string n);
    vec_t v;
    v.i = i; v.e = e; v.n = n;
    tbl.push_back(v);
  endtask
  task automatic drive(input in_t i);
    rst = i.rst; start_i = i.start; abort_i = i.abort; halt_i = i.halt; retire_i = i.retire;
  endtask
  task automatic check();
    out_t e, a;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    a = {core_rst_o, core_reset_o, run_o, done_o, timeout_o, cycle_cnt_o, retire_cnt_o};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %s, want %s", n, fmt(a), fmt(e));
    end
  endtask
  task automatic idle(input in_t i);
    drive(i);
    @(posedge clk);
    #1;
  endtask
  task automatic step(input in_t i, input out_t e, input string n);
    drive(i);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    check();
  endtask
  task automatic wait_run();
    for (int k = 0; k < 20 && !run_o; k++) idle(ii(0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    name_q.push_back("run_entry");
    check();
  endtask
  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish within the time limit");
    $fatal(1);
  end
  initial begin
    in_t R, HR, S, N;
    R = ii(0, 0, 0, 0, 1); HR = ii(0, 0, 0, 1, 1); S = ii(0, 1, 0, 0, 0); N = ii(0, 0, 0, 0, 0);
    drive(N);
    add(ii(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0), "reset");
    add(S,  mk(1, 0, 0, 0, 0, 0, 0), "rst1_a");
    add(N,  mk(1, 0, 0, 0, 0, 0, 0), "rst1_b");
    add(N,  mk(0, 1, 0, 0, 0, 0, 0), "rst2_a");
    add(N,  mk(0, 1, 0, 0, 0, 0, 0), "rst2_b");
    add(N,  mk(0, 1, 0, 0, 0, 0, 0), "rst2_c");
    add(R,  mk(0, 0, 1, 0, 0, 0, 0), "run0");
    add(HR, mk(0, 0, 1, 0, 0, 1, 1), "burst1_1");
    add(HR, mk(0, 0, 1, 0, 0, 2, 2), "burst1_2");
    add(HR, mk(0, 0, 1, 0, 0, 3, 3), "burst1_3");
    add(R,  mk(0, 0, 1, 0, 0, 4, 4), "halt_gap");
    add(HR, mk(0, 0, 1, 0, 0, 5, 5), "burst2_1");
    add(HR, mk(0, 0, 1, 0, 0, 6, 6), "burst2_2");
    add(HR, mk(0, 0, 1, 0, 0, 7, 7), "burst2_3");
    add(HR, mk(1, 0, 0, 1, 0, 8, 8), "halt_done");
    add(R,  mk(1, 0, 0, 1, 0, 8, 8), "done_frozen");
    foreach (tbl[k]) step(tbl[k].i, tbl[k].e, tbl[k].n);
    // budget timeout with halt low
    step(S, mk(1, 0, 0, 0, 0, 0, 0), "restart_clr");
    wait_run();
    repeat (198) idle(R);
    step(R, mk(0, 0, 1, 0, 0, 199, 199), "budget_199");
    step(R, mk(1, 0, 0, 1, 1, 200, 200), "timeout");
    step(R, mk(1, 0, 0, 1, 1, 200, 200), "timeout_frozen");
    // halt completes on the same cycle the budget runs out
    step(S, mk(1, 0, 0, 0, 0, 0, 0), "restart2");
    wait_run();
    repeat (196) idle(R);
    idle(HR);
    idle(HR);
    step(HR, mk(0, 0, 1, 0, 0, 199, 199), "tie_199");
    step(HR, mk(1, 0, 0, 1, 0, 200, 200), "halt_at_budget");
    // retire counting
    step(S, mk(1, 0, 0, 0, 0, 0, 0), "restart3");
    wait_run();
    for (int k = 0; k < 99; k++) idle(ii(0, 0, 0, 0, k[0]));
    step(R, mk(0, 0, 1, 0, 0, 100, 50), "retire_50");
    repeat (3) idle(ii(0, 0, 0, 1, 0));
    step(ii(0, 0, 0, 1, 0), mk(1, 0, 0, 1, 0, 104, 50), "retire_done");
    step(R, mk(1, 0, 0, 1, 0, 104, 50), "retire_frozen");
    step(S, mk(1, 0, 0, 0, 0, 0, 0), "retire_clr");
    // abort with simultaneous start at RUN cycle 10
    wait_run();
    repeat (9) idle(R);
    step(R, mk(0, 0, 1, 0, 0, 10, 10), "run10");
    step(ii(0, 1, 1, 0, 1), mk(1, 0, 0, 0, 0, 0, 0), "abort");
    for (int k = 0; k < 3; k++) step(N, mk(1, 0, 0, 0, 0, 0, 0), "abort_stay");
    // rst during RST2
    step(S, mk(1, 0, 0, 0, 0, 0, 0), "start4");
    step(N, mk(1, 0, 0, 0, 0, 0, 0), "start4_rst1");
    step(N, mk(0, 1, 0, 0, 0, 0, 0), "start4_rst2");
    step(ii(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0), "rst_mid");
    for (int k = 0; k < 3; k++) step(N, mk(1, 0, 0, 0, 0, 0, 0), "rst_stay");
`ifdef CPU_RUN_WATCHDOG_EN
    step(S, mk(1, 0, 0, 0, 0, 0, 0), "wd_start");
    wait_run();
    repeat (30) idle(N);
    step(N, mk(0, 0, 1, 0, 0, 31, 0), "wd_31");
    n_vec++;
    if (wdog_o !== 1'b0) begin
      n_err++;
      $display("FAIL wd_early: got wdog=%0b, want 0", wdog_o);
    end
    step(N, mk(1, 0, 0, 1, 1, 32, 0), "wd_done");
    n_vec++;
    if (wdog_o !== 1'b1) begin
      n_err++;
      $display("FAIL wd_flag: got wdog=%0b, want 1", wdog_o);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
